// File: rtl/systolic_edge_feeder.sv
// Transmit-side feeder for an N x N processing-element array: accepts operand
// vector pairs, skews them onto the west/north edges and sequences per-diagonal done flags.
module systolic_edge_feeder #(
  parameter int WIDTH         = 16,
  parameter int N             = 4,
  parameter int DRAIN_LAT     = 2,
  parameter int FINISH_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic [N*WIDTH-1:0]   s_data_a,
  input  logic [N*WIDTH-1:0]   s_data_b,
  output logic [N*WIDTH-1:0]   edge_a,
  output logic [N*WIDTH-1:0]   edge_b,
  output logic [2*N-2:0]       done_diag,
  output logic                 busy,
  output logic                 tile_done,
  output logic [CNT_W-1:0]     beat_count
);

  localparam int ND    = 2 * N - 1;
  localparam int MK_D  = ND + DRAIN_LAT;
  localparam int FIN_W = $clog2(FINISH_CYCLES + 1);
  localparam logic [FIN_W-1:0] FIN_LAST = FIN_W'(FINISH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIN_W-1:0]   fin_q, fin_d;
  logic [MK_D-1:0]    mk_q;
  logic               ready_int;
  logic               accept;
  logic               tile_done_int;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign ready_int = (state_q == IDLE) || (state_q == FEED);
  assign accept    = s_valid && ready_int && !reset;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fin_d         = fin_q;
    tile_done_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(1);
          state_d = s_last ? FLUSH : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          cnt_d = sat_inc(cnt_q);
          if (s_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        fin_d = '0;
        // The oldest marker position is done_diag[2N-2]: last diagonal has drained.
        if (mk_q[MK_D-1]) state_d = FINISH;
      end
      FINISH: begin
        if (fin_q == FIN_LAST) begin
          tile_done_int = 1'b1;
          state_d       = IDLE;
        end else begin
          fin_d = fin_q + FIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= '0;
      mk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      mk_q    <= {mk_q[MK_D-2:0], accept && s_last};
    end
  end

  // Lane i gets i+1 stages; empty cycles push +0 so the PE accumulators are untouched.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] a_q [i+1];
    logic [WIDTH-1:0] b_q [i+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        a_q[0] <= accept ? s_data_a[i*WIDTH +: WIDTH] : '0;
        b_q[0] <= accept ? s_data_b[i*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= i; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end

    assign edge_a[i*WIDTH +: WIDTH] = reset ? '0 : a_q[i];
    assign edge_b[i*WIDTH +: WIDTH] = reset ? '0 : b_q[i];
  end

  // Outputs are forced low during the reset cycle itself, not only afterwards.
  assign s_ready    = ready_int && !reset;
  assign busy       = (state_q != IDLE) && !reset;
  assign tile_done  = tile_done_int && !reset;
  assign done_diag  = reset ? '0 : mk_q[DRAIN_LAT +: ND];
  assign beat_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Randomized and directed bench for systolic_edge_feeder; expected outputs come
// from a timing-rule model (acceptance times, t_last arithmetic) kept in the bench.
module tb_systolic_edge_feeder;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int DL   = 2;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int ND   = 2 * N - 1;
  localparam int MAXC = 200;
  // Packed observation: {s_ready, busy, tile_done, done_diag, beat_count, edge_a, edge_b}
  localparam int EB_L = 0;
  localparam int EA_L = N * W;
  localparam int BC_L = 2 * N * W;
  localparam int DD_L = BC_L + CW;
  localparam int TD_B = DD_L + ND;
  localparam int BY_B = TD_B + 1;
  localparam int RD_B = TD_B + 2;
  localparam int OW   = TD_B + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid, s_ready, s_last;
  logic [N*W-1:0]   s_data_a, s_data_b, edge_a, edge_b;
  logic [ND-1:0]    done_diag;
  logic             busy, tile_done;
  logic [CW-1:0]    beat_count;

  int n_checks = 0;
  int n_err    = 0;

  logic           v_s [MAXC];
  logic           l_s [MAXC];
  logic           r_s [MAXC];
  logic [N*W-1:0] da_s[MAXC];
  logic [N*W-1:0] db_s[MAXC];
  logic [OW-1:0]  obs [MAXC];
  logic [OW-1:0]  expv[MAXC];

  systolic_edge_feeder #(
    .WIDTH(W), .N(N), .DRAIN_LAT(DL), .FINISH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data_a(s_data_a), .s_data_b(s_data_b), .edge_a(edge_a), .edge_b(edge_b),
    .done_diag(done_diag), .busy(busy), .tile_done(tile_done), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] sample();
    return {s_ready, busy, tile_done, done_diag, beat_count, edge_a, edge_b};
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      v_s[c]  = 1'b0;
      l_s[c]  = 1'b0;
      r_s[c]  = 1'b0;
      da_s[c] = {$urandom, $urandom};
      db_s[c] = {$urandom, $urandom};
    end
  endtask

  // Reference: a beat accepted at t shows on lane i at t+1+i; the last beat at
  // t_last schedules diag d at t_last+1+d+DL and tile_done at t_last+2N-1+DL+FC.
  function automatic void build_model(input int nc);
    logic [W-1:0]  ea [MAXC][N];
    logic [W-1:0]  eb [MAXC][N];
    logic [ND-1:0] ed [MAXC];
    logic          et [MAXC];
    logic          er [MAXC];
    logic          eby[MAXC];
    logic [CW-1:0] ec [MAXC];
    int tl, td, cnt;
    bit active, rdy;
    logic [N*W-1:0] av, bv;
    for (int c = 0; c < MAXC; c++) begin
      for (int i = 0; i < N; i++) begin ea[c][i] = '0; eb[c][i] = '0; end
      ed[c] = '0; et[c] = 1'b0; er[c] = 1'b0; eby[c] = 1'b0; ec[c] = '0;
    end
    tl = -1; td = -1; cnt = 0; active = 0;
    for (int c = 0; c < nc; c++) begin
      if (r_s[c]) begin
        for (int k = c; k < MAXC; k++) begin
          for (int i = 0; i < N; i++) begin ea[k][i] = '0; eb[k][i] = '0; end
          ed[k] = '0; et[k] = 1'b0;
        end
        tl = -1; td = -1; cnt = 0; active = 0;
        continue;
      end
      rdy    = !(tl >= 0 && c > tl && c <= td);
      er[c]  = rdy;
      eby[c] = active;
      ec[c]  = CW'(cnt);
      if (v_s[c] && rdy) begin
        cnt    = !active ? 1 : (cnt == 2**CW - 1) ? cnt : cnt + 1;
        active = 1;
        for (int i = 0; i < N; i++)
          if (c + 1 + i < MAXC) begin
            ea[c+1+i][i] = da_s[c][i*W +: W];
            eb[c+1+i][i] = db_s[c][i*W +: W];
          end
        if (l_s[c]) begin
          tl = c;
          td = c + 2 * N - 1 + DL + FC;
          for (int d = 0; d < ND; d++)
            if (c + 1 + d + DL < MAXC) ed[c+1+d+DL][d] = 1'b1;
          if (td < MAXC) et[td] = 1'b1;
        end
      end
      if (c == td) begin active = 0; tl = -1; td = -1; end
    end
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < N; i++) begin
        av[i*W +: W] = ea[c][i];
        bv[i*W +: W] = eb[c][i];
      end
      expv[c] = {er[c], eby[c], et[c], ed[c], ec[c], av, bv};
    end
  endfunction

  // Two reset cycles, then nc recorded cycles driven from the stimulus arrays.
  task automatic run_stream(input int nc);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    end
    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      reset = r_s[c]; s_valid = v_s[c]; s_last = l_s[c];
      s_data_a = da_s[c]; s_data_b = db_s[c];
      @(negedge clk);
      obs[c] = sample();
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    build_model(nc);
  endtask

  task automatic test_reset();
    logic [OW-1:0] idle_v;
    idle_v = '0;
    idle_v[RD_B] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      reset = 1'b0; s_valid = 1'b1;
      s_data_a = {$urandom, $urandom}; s_data_b = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample() !== '0) begin
      n_err++; $display("FAIL reset_cycle got %h want 0", sample());
    end
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (sample() !== idle_v) begin
        n_err++; $display("FAIL reset_after%0d got %h want %h", k, sample(), idle_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    clear_stim();
    for (int c = 0; c < 3; c++) v_s[c] = 1'b1;
    l_s[2] = 1'b1;
    run_stream(20);
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL basic c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if ({obs[5][DD_L], obs[11][DD_L+ND-1], obs[14][TD_B], obs[15][RD_B]} !== 4'b1111) begin
      n_err++; $display("FAIL basic_times got %b want 1111",
                        {obs[5][DD_L], obs[11][DD_L+ND-1], obs[14][TD_B], obs[15][RD_B]});
    end
    n_checks++;
    if (obs[6][EA_L+3*W +: W] !== da_s[2][3*W +: W] || obs[15][BC_L +: CW] !== 4'd3) begin
      n_err++; $display("FAIL basic_lane3_count got %h/%0d want %h/3",
                        obs[6][EA_L+3*W +: W], obs[15][BC_L +: CW], da_s[2][3*W +: W]);
    end
  endtask

  task automatic test_bubble();
    clear_stim();
    v_s[0] = 1'b1; v_s[2] = 1'b1; v_s[3] = 1'b1; l_s[3] = 1'b1;
    run_stream(22);
    for (int c = 0; c < 22; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL bubble c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if (obs[2][EA_L +: W] !== 16'h0000 || obs[6][DD_L] !== 1'b1 || obs[15][TD_B] !== 1'b1) begin
      n_err++; $display("FAIL bubble_times got %h %b %b want 0000 1 1",
                        obs[2][EA_L +: W], obs[6][DD_L], obs[15][TD_B]);
    end
  endtask

  task automatic test_single();
    clear_stim();
    v_s[0] = 1'b1; l_s[0] = 1'b1;
    run_stream(18);
    for (int c = 0; c < 18; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL single c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if (obs[3][DD_L] !== 1'b1 || obs[12][TD_B] !== 1'b1 || obs[12][BC_L +: CW] !== 4'd1) begin
      n_err++; $display("FAIL single_times got %b %b %0d want 1 1 1",
                        obs[3][DD_L], obs[12][TD_B], obs[12][BC_L +: CW]);
    end
  endtask

  task automatic test_mid_reset();
    clear_stim();
    for (int c = 0; c < 3; c++) v_s[c] = 1'b1;
    l_s[2] = 1'b1; r_s[7] = 1'b1;
    v_s[10] = 1'b1; v_s[11] = 1'b1; l_s[11] = 1'b1;
    run_stream(30);
    for (int c = 0; c < 30; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL midreset c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if (obs[11][DD_L+ND-1] !== 1'b0 || obs[14][TD_B] !== 1'b0 || obs[23][TD_B] !== 1'b1) begin
      n_err++; $display("FAIL midreset_pulses got %b %b %b want 0 0 1",
                        obs[11][DD_L+ND-1], obs[14][TD_B], obs[23][TD_B]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int c = 0; c < 18; c++) v_s[c] = 1'b1;
    for (int c = 2; c <= 14; c++) l_s[c] = 1'b1;
    l_s[17] = 1'b1;
    run_stream(35);
    for (int c = 0; c < 35; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL b2b c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if (obs[16][EA_L +: W] !== da_s[15][W-1:0] || obs[18][BC_L +: CW] !== 4'd3 ||
        obs[29][TD_B] !== 1'b1) begin
      n_err++; $display("FAIL b2b_points got %h %0d %b want %h 3 1",
                        obs[16][EA_L +: W], obs[18][BC_L +: CW], obs[29][TD_B], da_s[15][W-1:0]);
    end
  endtask

  task automatic test_saturate();
    clear_stim();
    for (int c = 0; c < 20; c++) v_s[c] = 1'b1;
    l_s[19] = 1'b1;
    run_stream(40);
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_err++; $display("FAIL saturate c%0d got %h want %h", c, obs[c], expv[c]);
      end
    end
    n_checks++;
    if (obs[20][BC_L +: CW] !== 4'hF) begin
      n_err++; $display("FAIL saturate_count got %0d want 15", obs[20][BC_L +: CW]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int c = 0; c < 150; c++) begin
        v_s[c] = ($urandom_range(99) < 70);
        l_s[c] = ($urandom_range(99) < 20);
        r_s[c] = (c > 0) && ($urandom_range(99) < 2);
      end
      run_stream(150);
      for (int c = 0; c < 150; c++) begin
        n_checks++;
        if (obs[c] !== expv[c]) begin
          n_err++; $display("FAIL random%0d c%0d got %h want %h", r, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    s_data_a = '0; s_data_b = '0;
    test_reset();
    test_basic();
    test_bubble();
    test_single();
    test_mid_reset();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
